// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, the EX/MEM access FSM
// state, and packed bundles for the pipeline-register control and data fields.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  // REQ: a data access may be outstanding (or none is needed).
  // HELD: the access completed but the instruction has not advanced yet.
  typedef enum logic {
    REQ  = 1'b0,
    HELD = 1'b1
  } exmem_state_t;

  typedef struct packed {
    logic       reg_wr;
    logic       halt;
    logic       dren;
    logic       dwen;
    logic [1:0] mem_to_reg;
  } exmem_ctrl_t;

  typedef struct packed {
    word_t    alu_out;
    word_t    rdat2;
    word_t    pc4;
    word_t    imm;
    regbits_t wsel;
  } exmem_data_t;

endpackage

// File: rtl/ex_mem_if.sv
// Port bundle for the EX/MEM pipeline register. Optional macro EX_MEM_PERF_EN
// adds the stall_cnt performance counter signal.
interface ex_mem_if;
  import cpu_types_pkg::*;

  logic     CLK;
  logic     RST;
  logic     en;
  logic     flush;
  word_t    alu_out_i;
  word_t    rdat2_i;
  word_t    pc4_i;
  word_t    imm_i;
  regbits_t wsel_i;
  logic     RegWr_i;
  logic     halt_i;
  logic     dREN_i;
  logic     dWEN_i;
  logic [1:0] MemToReg_i;
  logic     dhit;
  word_t    dmemload;
  word_t    alu_out_o;
  word_t    pc4_o;
  word_t    imm_o;
  word_t    dload_o;
  regbits_t wsel_o;
  logic     RegWr_o;
  logic     halt_o;
  logic [1:0] MemToReg_o;
  logic     dmemREN;
  logic     dmemWEN;
  word_t    dmemaddr;
  word_t    dmemstore;
  logic     mem_stall;
`ifdef EX_MEM_PERF_EN
  word_t    stall_cnt;
`endif

  modport exmem (
    input  CLK, RST, en, flush, alu_out_i, rdat2_i, pc4_i, imm_i, wsel_i,
           RegWr_i, halt_i, dREN_i, dWEN_i, MemToReg_i, dhit, dmemload,
    output alu_out_o, pc4_o, imm_o, dload_o, wsel_o, RegWr_o, halt_o,
           MemToReg_o, dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall
`ifdef EX_MEM_PERF_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with data-cache request FSM and memory stall.
// Optional macro EX_MEM_PERF_EN adds a saturating stall-cycle counter output.
module ex_mem
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       flush,
  input  word_t      alu_out_i,
  input  word_t      rdat2_i,
  input  word_t      pc4_i,
  input  word_t      imm_i,
  input  regbits_t   wsel_i,
  input  logic       RegWr_i,
  input  logic       halt_i,
  input  logic       dREN_i,
  input  logic       dWEN_i,
  input  logic [1:0] MemToReg_i,
  input  logic       dhit,
  input  word_t      dmemload,
  output word_t      alu_out_o,
  output word_t      pc4_o,
  output word_t      imm_o,
  output word_t      dload_o,
  output regbits_t   wsel_o,
  output logic       RegWr_o,
  output logic       halt_o,
  output logic [1:0] MemToReg_o,
  output logic       dmemREN,
  output logic       dmemWEN,
  output word_t      dmemaddr,
  output word_t      dmemstore,
`ifdef EX_MEM_PERF_EN
  output word_t      stall_cnt,
`endif
  output logic       mem_stall
);

  exmem_ctrl_t  ctrl_q, ctrl_d;
  exmem_data_t  data_q, data_d;
  word_t        dload_q, dload_d;
  exmem_state_t state_q, state_d;

  logic in_req;
  logic access;
  logic dmem_ren;
  logic dmem_wen;
  logic stall;
  logic advance;

  always_comb begin
    in_req   = (state_q == REQ);
    access   = ctrl_q.dren | ctrl_q.dwen;
    // A write always wins over a simultaneous read request.
    dmem_ren = ctrl_q.dren & ~ctrl_q.dwen & in_req;
    dmem_wen = ctrl_q.dwen & in_req;
    stall    = access & ~dhit & in_req;
    advance  = en & ~stall & ~ctrl_q.halt;
  end

  // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
  always_comb begin
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    dload_d = dload_q;
    state_d = state_q;

    // A latched halt freezes the whole stage, flush included, until reset.
    if (!ctrl_q.halt) begin
      if (dmem_ren && dhit) dload_d = dmemload;

      if (flush) begin
        ctrl_d  = '0;
        state_d = REQ;
      end else begin
        if (advance) begin
          ctrl_d = '{reg_wr: RegWr_i, halt: halt_i, dren: dREN_i,
                     dwen: dWEN_i, mem_to_reg: MemToReg_i};
          data_d = '{alu_out: alu_out_i, rdat2: rdat2_i, pc4: pc4_i,
                     imm: imm_i, wsel: wsel_i};
        end
        unique case (state_q)
          REQ:     if (access && dhit && !advance) state_d = HELD;
          HELD:    if (advance)                    state_d = REQ;
          default: state_d = REQ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: reset clears every register, including data fields, so a late dhit finds no access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      dload_q <= '0;
      state_q <= REQ;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      dload_q <= dload_d;
      state_q <= state_d;
    end
  end

`ifdef EX_MEM_PERF_EN
  word_t stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign alu_out_o  = data_q.alu_out;
  assign pc4_o      = data_q.pc4;
  assign imm_o      = data_q.imm;
  assign wsel_o     = data_q.wsel;
  assign dload_o    = dload_q;
  assign RegWr_o    = ctrl_q.reg_wr;
  assign halt_o     = ctrl_q.halt;
  assign MemToReg_o = ctrl_q.mem_to_reg;
  assign dmemREN    = dmem_ren;
  assign dmemWEN    = dmem_wen;
  assign dmemaddr   = data_q.alu_out;
  assign dmemstore  = data_q.rdat2;
  assign mem_stall  = stall;

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for ex_mem: load stall, held store, flush,
// REN/WEN conflict, sticky halt, reset mid-access and (optionally) stall_cnt.
module tb_ex_mem;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       en, flush;
  word_t      alu_out_i, rdat2_i, pc4_i, imm_i;
  regbits_t   wsel_i;
  logic       RegWr_i, halt_i, dREN_i, dWEN_i;
  logic [1:0] MemToReg_i;
  logic       dhit;
  word_t      dmemload;
  word_t      alu_out_o, pc4_o, imm_o, dload_o;
  regbits_t   wsel_o;
  logic       RegWr_o, halt_o;
  logic [1:0] MemToReg_o;
  logic       dmemREN, dmemWEN;
  word_t      dmemaddr, dmemstore;
  logic       mem_stall;
`ifdef EX_MEM_PERF_EN
  word_t      stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ex_mem dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .alu_out_i(alu_out_i), .rdat2_i(rdat2_i), .pc4_i(pc4_i), .imm_i(imm_i),
    .wsel_i(wsel_i), .RegWr_i(RegWr_i), .halt_i(halt_i), .dREN_i(dREN_i),
    .dWEN_i(dWEN_i), .MemToReg_i(MemToReg_i), .dhit(dhit), .dmemload(dmemload),
    .alu_out_o(alu_out_o), .pc4_o(pc4_o), .imm_o(imm_o), .dload_o(dload_o),
    .wsel_o(wsel_o), .RegWr_o(RegWr_o), .halt_o(halt_o), .MemToReg_o(MemToReg_o),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore),
`ifdef EX_MEM_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .mem_stall(mem_stall)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; flush = 1'b0;
    alu_out_i = '0; rdat2_i = '0; pc4_i = '0; imm_i = '0; wsel_i = '0;
    RegWr_i = 1'b0; halt_i = 1'b0; dREN_i = 1'b0; dWEN_i = 1'b0;
    MemToReg_i = 2'd0; dhit = 1'b0; dmemload = '0;
    tick(); tick();

    check("rst_alu_out", alu_out_o, 32'h0);
    check("rst_regwr", RegWr_o, 1'b0);
    check("rst_halt", halt_o, 1'b0);
    check("rst_dload", dload_o, 32'h0);
    check("rst_dmemren", dmemREN, 1'b0);
    check("rst_dmemwen", dmemWEN, 1'b0);
    check("rst_stall", mem_stall, 1'b0);

    // Load with three miss cycles then a hit.
    RST = 1'b0; en = 1'b1; dREN_i = 1'b1; alu_out_i = 32'h100; rdat2_i = 32'h55;
    pc4_i = 32'h104; imm_i = 32'h1234_0000; wsel_i = 5'd5; RegWr_i = 1'b1;
    MemToReg_i = 2'd1;
    tick();
    dREN_i = 1'b0; alu_out_i = 32'h200; RegWr_i = 1'b0; MemToReg_i = 2'd0;
    wsel_i = 5'd7; pc4_i = 32'h204;
    #1;
    check("ld_pc4", pc4_o, 32'h104);
    check("ld_imm", imm_o, 32'h1234_0000);
    check("ld_wsel", wsel_o, 32'd5);
    check("ld_memtoreg", MemToReg_o, 32'd1);
    check("ld_addr", dmemaddr, 32'h100);
    check("ld_store_data", dmemstore, 32'h55);
    check("ld_ren", dmemREN, 1'b1);
    check("ld_stall_c1", mem_stall, 1'b1);
    tick();
    check("ld_stall_c2", mem_stall, 1'b1);
    tick();
    check("ld_stall_c3", mem_stall, 1'b1);
    check("ld_hold_alu", alu_out_o, 32'h100);
    tick();
    dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
    #1;
    check("ld_stall_hit", mem_stall, 1'b0);
    tick();
    check("ld_dload", dload_o, 32'hDEAD_BEEF);
    check("ld_advanced", alu_out_o, 32'h200);
    check("ld_adv_wsel", wsel_o, 32'd7);
    check("ld_ren_after", dmemREN, 1'b0);
    dhit = 1'b0;

    // Store that hits while the stage is not allowed to advance.
    dWEN_i = 1'b1; alu_out_i = 32'h300; rdat2_i = 32'hCAFE;
    tick();
    en = 1'b0; dhit = 1'b1;
    #1;
    check("st_wen_issue", dmemWEN, 1'b1);
    check("st_store_data", dmemstore, 32'hCAFE);
    tick();
    check("st_held1_wen", dmemWEN, 1'b0);
    check("st_held1_stall", mem_stall, 1'b0);
    tick();
    check("st_held2_wen", dmemWEN, 1'b0);
    check("st_held2_stall", mem_stall, 1'b0);
    check("st_held2_addr", dmemaddr, 32'h300);
    en = 1'b1; dWEN_i = 1'b0; dhit = 1'b0; alu_out_i = 32'h400;
    tick();
    check("st_release_alu", alu_out_o, 32'h400);
    check("st_release_wen", dmemWEN, 1'b0);

    // Flush has priority over enable and clears controls.
    RegWr_i = 1'b1; dREN_i = 1'b1; MemToReg_i = 2'd2; alu_out_i = 32'h500;
    tick();
    check("fl_pre_regwr", RegWr_o, 1'b1);
    check("fl_pre_stall", mem_stall, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0; RegWr_i = 1'b0; dREN_i = 1'b0; MemToReg_i = 2'd0;
    #1;
    check("fl_regwr", RegWr_o, 1'b0);
    check("fl_ren", dmemREN, 1'b0);
    check("fl_memtoreg", MemToReg_o, 32'd0);
    check("fl_stall", mem_stall, 1'b0);

    // Simultaneous read and write: write wins, read data is not captured.
    dREN_i = 1'b1; dWEN_i = 1'b1;
    tick();
    dREN_i = 1'b0; dWEN_i = 1'b0;
    #1;
    check("rw_wen", dmemWEN, 1'b1);
    check("rw_ren", dmemREN, 1'b0);
    check("rw_stall", mem_stall, 1'b1);
    dhit = 1'b1; dmemload = 32'h1111;
    tick();
    check("rw_no_capture", dload_o, 32'hDEAD_BEEF);
    dhit = 1'b0;

    // Sticky halt.
    halt_i = 1'b1; RegWr_i = 1'b1; alu_out_i = 32'h600;
    tick();
    halt_i = 1'b0; RegWr_i = 1'b0; alu_out_i = 32'h700;
    #1;
    check("ht_halt", halt_o, 1'b1);
    tick();
    check("ht_frozen_alu", alu_out_o, 32'h600);
    check("ht_frozen_regwr", RegWr_o, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ht_flush_halt", halt_o, 1'b1);
    check("ht_flush_regwr", RegWr_o, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("ht_rst_halt", halt_o, 1'b0);
    check("ht_rst_alu", alu_out_o, 32'h0);

    // Reset in the middle of an outstanding load.
    dREN_i = 1'b1; alu_out_i = 32'h800;
    tick();
    check("ra_ren", dmemREN, 1'b1);
    RST = 1'b1; en = 1'b0; dREN_i = 1'b0;
    tick();
    RST = 1'b0; dhit = 1'b1; dmemload = 32'h0BAD;
    #1;
    check("ra_ren_cleared", dmemREN, 1'b0);
    check("ra_stall_cleared", mem_stall, 1'b0);
    tick();
    check("ra_late_hit", dload_o, 32'h0);
    dhit = 1'b0; en = 1'b1; dREN_i = 1'b1;
    tick();
    check("ra_state_req", dmemREN, 1'b1);

`ifdef EX_MEM_PERF_EN
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    check("pc_zero", stall_cnt, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    check("pc_five", stall_cnt, 32'd5);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.stall_cnt_q;
    tick();
    check("pc_saturate", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
